maxpool2_seq_ctrl: RTL and testbench

- Synthesizable sequencer for the 2x2 / stride-2 integer max-pool stage after conv2d layer 2 (16x16x32 signed 25-bit maps -> 8x8x32).
- Walks every channel and window of an input feature-map RAM (1-cycle read latency) and reduces each window with a signed max.
- Writes one result per window to the output RAM through a ready/valid write port.
- Handshakes with the layer scheduler via start/busy/done.

---
 rtl/maxpool2_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_maxpool2_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2_seq_ctrl.sv
// maxpool2_seq_ctrl: walks every channel/window of a feature map and writes the signed 2x2 max of each window.
module maxpool2_seq_ctrl #(
    parameter int WIDTH_IN = 16,
    parameter int HEIGHT_IN = 16,
    parameter int CHANNELS = 32,
    parameter int DATA_W = 25,
    localparam int WIDTH_OUT = (WIDTH_IN - 2) / 2 + 1,
    localparam int HEIGHT_OUT = (HEIGHT_IN - 2) / 2 + 1,
    localparam int IN_AW = $clog2(CHANNELS * WIDTH_IN * HEIGHT_IN),
    localparam int OUT_AW = $clog2(CHANNELS * WIDTH_OUT * HEIGHT_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IN_AW-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [OUT_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int HW = HEIGHT_OUT > 1 ? $clog2(HEIGHT_OUT) : 1;
    localparam int WW = WIDTH_OUT > 1 ? $clog2(WIDTH_OUT) : 1;

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, MAX, WR, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [HW-1:0] ph_q, ph_d;
    logic [WW-1:0] pw_q, pw_d;
    logic signed [DATA_W-1:0] acc_q, acc_d, mx;
    logic busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, wr_valid_q, wr_valid_d;
    logic [IN_AW-1:0] rd_addr_q, rd_addr_d;
    logic [OUT_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic pw_wrap, ph_wrap, c_wrap, dy, dx;

    assign busy = busy_q;
    assign done = done_q;
    assign rd_en = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    always_comb begin
        mx = ($signed(rd_data) > acc_q) ? $signed(rd_data) : acc_q;
        pw_wrap = 32'(pw_q) == WIDTH_OUT - 1;
        ph_wrap = 32'(ph_q) == HEIGHT_OUT - 1;
        c_wrap = 32'(c_q) == CHANNELS - 1;
        state_d = state_q;
        c_d = c_q;
        ph_d = ph_q;
        pw_d = pw_q;
        acc_d = acc_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RD0;
                c_d = '0;
                ph_d = '0;
                pw_d = '0;
            end
            RD0: state_d = RD1;
            RD1: begin
                state_d = RD2;
                acc_d = rd_data;
            end
            RD2: begin
                state_d = RD3;
                acc_d = mx;
            end
            RD3: begin
                state_d = MAX;
                acc_d = mx;
            end
            MAX: begin
                state_d = WR;
                acc_d = mx;
                wr_data_d = mx;
                wr_addr_d = OUT_AW'(32'(c_q) * WIDTH_OUT * HEIGHT_OUT + 32'(ph_q) * WIDTH_OUT + 32'(pw_q));
            end
            WR: if (wr_ready) begin
                state_d = (c_wrap && ph_wrap && pw_wrap) ? DONE : RD0;
                pw_d = pw_wrap ? '0 : pw_q + 1'b1;
                ph_d = pw_wrap ? (ph_wrap ? '0 : ph_q + 1'b1) : ph_q;
                c_d = (pw_wrap && ph_wrap) ? c_q + 1'b1 : c_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are decoded from the next state and next counters.
        dy = state_d == RD2 || state_d == RD3;
        dx = state_d == RD1 || state_d == RD3;
        rd_en_d = state_d == RD0 || state_d == RD1 || state_d == RD2 || state_d == RD3;
        rd_addr_d = rd_en_d ? IN_AW'(32'(c_d) * WIDTH_IN * HEIGHT_IN + (2 * 32'(ph_d) + 32'(dy)) * WIDTH_IN
                                    + 2 * 32'(pw_d) + 32'(dx)) : '0;
        wr_valid_d = state_d == WR;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q <= '0;
            ph_q <= '0;
            pw_q <= '0;
            acc_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_en_q <= 1'b0;
            rd_addr_q <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            c_q <= c_d;
            ph_q <= ph_d;
            pw_q <= pw_d;
            acc_q <= acc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rd_en_q <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_maxpool2_seq_ctrl.sv
// tb_maxpool2_seq_ctrl: directed table-driven bench on a 4x4x2 instance plus a 5x5x1 odd-size instance.
module tb_maxpool2_seq_ctrl;
    localparam int DW = 25;
    localparam int MINV = -16777216;
    localparam int MAXV = 16777215;

    typedef struct {
        int t0, t1, t2, t3;
        int exp;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_ready = 1'b1;
    logic busy, done, rd_en, wr_valid;
    logic [4:0] rd_addr;
    logic [2:0] wr_addr;
    logic [DW-1:0] rd_data, wr_data;
    logic start_b = 1'b0;
    logic busy_b, done_b, rd_en_b, wr_valid_b;
    logic [4:0] rd_addr_b;
    logic [1:0] wr_addr_b;
    logic [DW-1:0] rd_data_b, wr_data_b;
    logic [DW-1:0] mem [32];
    logic [DW-1:0] mem_b [32];

    int checks = 0, failures = 0, cyc = 0;
    int done_n = 0, done_cyc = 0, pass_start = 0;
    int done_nb = 0, done_cyc_b = 0, pass_start_b = 0, rd_cnt_b = 0, bad_rd_b = 0;
    logic busy_p = 1'b0, busy_pb = 1'b0;
    int wq_a[$], wq_ab[$];
    logic [DW-1:0] wq_d[$], wq_db[$];
    vec_t tbl [16];

    always #5 clk = ~clk;

    maxpool2_seq_ctrl #(.WIDTH_IN(4), .HEIGHT_IN(4), .CHANNELS(2), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data));

    maxpool2_seq_ctrl #(.WIDTH_IN(5), .HEIGHT_IN(5), .CHANNELS(1), .DATA_W(DW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .wr_valid(wr_valid_b), .wr_ready(1'b1),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b));

    // Input RAMs with one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= mem[rd_addr];
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
    end

    always @(negedge clk) begin
        busy_p <= busy;
        busy_pb <= busy_b;
        if (busy && !busy_p) pass_start <= cyc;
        if (busy_b && !busy_pb) pass_start_b <= cyc;
        if (done) begin
            done_n <= done_n + 1;
            done_cyc <= cyc;
        end
        if (done_b) begin
            done_nb <= done_nb + 1;
            done_cyc_b <= cyc;
        end
        if (wr_valid && wr_ready) begin
            wq_a.push_back(int'(wr_addr));
            wq_d.push_back(wr_data);
        end
        if (wr_valid_b) begin
            wq_ab.push_back(int'(wr_addr_b));
            wq_db.push_back(wr_data_b);
        end
        if (rd_en_b) begin
            rd_cnt_b <= rd_cnt_b + 1;
            if (rd_addr_b % 5 == 4 || rd_addr_b >= 20) bad_rd_b <= bad_rd_b + 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pass(input int p);
        for (int w = 0; w < 8; w++) begin
            int b;
            b = (w / 4) * 16 + ((w % 4) / 2) * 8 + (w % 2) * 2;
            mem[b] = 25'(tbl[p*8+w].t0);
            mem[b+1] = 25'(tbl[p*8+w].t1);
            mem[b+4] = 25'(tbl[p*8+w].t2);
            mem[b+5] = 25'(tbl[p*8+w].t3);
        end
    endtask

    task automatic wait_done(input int d0, input string nm);
        for (int n = 0; n < 400 && done_n == d0; n++) tick();
        chk(nm, done_n, d0 + 1);
    endtask

    task automatic run_pass(input string nm);
        int d0;
        d0 = done_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0, nm);
    endtask

    task automatic check_writes(input int w0, input int p);
        chk("wr_count", wq_a.size(), w0 + 8);
        for (int w = 0; w < 8; w++)
            if (w0 + w < wq_a.size()) begin
                chk($sformatf("wr_addr[%0d]", w), wq_a[w0+w], w);
                chk($sformatf("wr_data[p%0d w%0d]", p, w), $signed(wq_d[w0+w]), tbl[p*8+w].exp);
            end
    endtask

    initial begin
        int w0, d0;
        logic found;
        tbl = '{
            '{0, 1, 4, 5, 5}, '{2, 3, 6, 7, 7}, '{8, 9, 12, 13, 13}, '{10, 11, 14, 15, 15},
            '{16, 17, 20, 21, 21}, '{18, 19, 22, 23, 23}, '{24, 25, 28, 29, 29}, '{26, 27, 30, 31, 31},
            '{-5, -3, -100, -4, -3}, '{MINV, MINV, MINV, MINV, MINV}, '{MAXV, MINV, 0, -1, MAXV},
            '{3, 9, 2, 1, 9}, '{1, 2, 30, 4, 30}, '{1, 2, 3, 40, 40}, '{-8, -7, -6, -9, -6}, '{7, 7, 7, 7, 7}};
        for (int i = 0; i < 32; i++) mem_b[i] = 25'(i);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ctrl", {busy, done, rd_en, wr_valid}, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Ramp map, full-rate write port.
        load_pass(0);
        w0 = wq_a.size();
        run_pass("done_ramp");
        check_writes(w0, 0);
        chk("latency_ramp", done_cyc - pass_start + 1, 49);
        chk("idle_after_ramp", busy, 0);

        // Signed extremes, ties and each tap position winning.
        load_pass(1);
        w0 = wq_a.size();
        run_pass("done_signed");
        check_writes(w0, 1);

        // Backpressure: three stalled cycles on the second window's write.
        load_pass(0);
        w0 = wq_a.size();
        d0 = done_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            found = wr_valid && wr_addr == 3'd0;
        end
        chk("bp_first_write", found, 1);
        @(posedge clk);
        #1 wr_ready = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            found = wr_valid;
        end
        chk("bp_second_write", found, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_valid", wr_valid, 1);
            chk("bp_addr", wr_addr, 1);
            chk("bp_data", wr_data, 7);
            chk("bp_no_rd", rd_en, 0);
        end
        @(posedge clk);
        #1 wr_ready = 1'b1;
        wait_done(d0, "done_bp");
        check_writes(w0, 0);
        chk("latency_bp", done_cyc - pass_start + 1, 52);

        // Abort with reset during the third read of window 5, then restart.
        d0 = done_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            found = rd_en && rd_addr == 5'd22;
        end
        chk("abort_point", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctrl", {busy, done, rd_en, wr_valid}, 0);
        chk("abort_addrs", {rd_addr, wr_addr}, 0);
        chk("abort_data", wr_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) tick();
        chk("abort_no_done", done_n, d0);
        chk("abort_idle", busy, 0);
        w0 = wq_a.size();
        run_pass("done_restart");
        check_writes(w0, 0);

        // start held high: one pass, then a new pass from the first IDLE cycle.
        w0 = wq_a.size();
        d0 = done_n;
        start = 1'b1;
        wait_done(d0, "done_held");
        chk("held_writes", wq_a.size(), w0 + 8);
        chk("held_idle_gap", busy, 0);
        tick();
        chk("held_restart_rd", rd_en, 1);
        chk("held_restart_addr", rd_addr, 0);
        start = 1'b0;
        wait_done(d0 + 1, "done_held2");
        check_writes(w0 + 8, 0);
        repeat (10) tick();
        chk("held_done_count", done_n, d0 + 2);

        // Odd 5x5 map: last row and column dropped.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int n = 0; n < 200 && done_nb == 0; n++) tick();
        chk("odd_done", done_nb, 1);
        chk("odd_wr_count", wq_ab.size(), 4);
        for (int w = 0; w < 4 && w < wq_ab.size(); w++) begin
            chk("odd_wr_addr", wq_ab[w], w);
            chk("odd_wr_data", $signed(wq_db[w]), (w / 2) * 10 + (w % 2) * 2 + 6);
        end
        chk("odd_rd_count", rd_cnt_b, 16);
        chk("odd_bad_reads", bad_rd_b, 0);
        chk("odd_latency", done_cyc_b - pass_start_b + 1, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
